// File: rtl/adsr_voice_alloc_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adsr_voice_alloc_if : note-on request handshake and voice grant report
// Rev 1.0
// ---------------------------------------------------------------------------
interface adsr_voice_alloc_if #(
  parameter int FCW_W = 32,
  parameter int ID_W  = 2
);
  logic             req_valid;
  logic             req_ready;
  logic [FCW_W-1:0] req_fcw;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic             grant_stolen;

  modport master (
    output req_valid, req_fcw,
    input  req_ready, grant_valid, grant_id, grant_stolen
  );

  modport slave (
    input  req_valid, req_fcw,
    output req_ready, grant_valid, grant_id, grant_stolen
  );
endinterface
`default_nettype wire

// File: rtl/adsr_voice_alloc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adsr_voice_alloc : shares N_VOICE ADSR/DDS voices, free-first then oldest steal
// Rev 1.0
// ---------------------------------------------------------------------------
module adsr_voice_alloc #(
  parameter int N_VOICE = 4,
  parameter int FCW_W   = 32,
  parameter int AGE_W   = 16
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  adsr_voice_alloc_if.slave                  bus,
  input  wire logic [N_VOICE-1:0]            i_voice_idle,
  output logic      [N_VOICE-1:0]            o_voice_start,
  output logic      [N_VOICE*FCW_W-1:0]      o_voice_fcw,
  output logic      [$clog2(N_VOICE):0]      o_active_cnt
);

  localparam int ID_W  = $clog2(N_VOICE);
  localparam int CNT_W = ID_W + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SELECT = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [FCW_W-1:0]   r_fcw_req;
  logic [ID_W-1:0]    r_sel;
  logic               r_stolen;
  logic [ID_W-1:0]    w_sel;
  logic               w_stolen;
  logic [AGE_W-1:0]   w_best_age;
  logic [N_VOICE-1:0] r_pending;
  logic [N_VOICE-1:0] w_free;
  logic [N_VOICE-1:0] w_start;
  logic [N_VOICE-1:0] w_busy;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_accept;
  logic               w_issue;
  logic [AGE_W-1:0]   r_age       [N_VOICE];
  logic [FCW_W-1:0]   r_voice_fcw [N_VOICE];

  assign w_accept = bus.req_valid && (r_state == S_IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SELECT;
      S_SELECT: w_state_nxt = S_ISSUE;
      S_ISSUE:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state and selection
  always_comb begin
    w_issue          = (r_state == S_ISSUE);
    w_start          = '0;
    if (w_issue) w_start[r_sel] = 1'b1;
    bus.req_ready    = (r_state == S_IDLE);
    bus.grant_valid  = w_issue;
    bus.grant_id     = w_issue ? r_sel : '0;
    bus.grant_stolen = w_issue & r_stolen;
  end

  assign o_voice_start = w_start;

  // Lowest free voice wins; with none free, the oldest (lowest index on tie) is stolen
  always_comb begin
    w_free     = i_voice_idle & ~r_pending;
    w_sel      = '0;
    w_stolen   = 1'b1;
    w_best_age = r_age[0];
    for (int v = N_VOICE - 1; v >= 0; v--) begin
      if (w_free[v]) begin
        w_sel    = ID_W'(v);
        w_stolen = 1'b0;
      end
    end
    if (w_stolen) begin
      for (int v = 1; v < N_VOICE; v++) begin
        if (r_age[v] > w_best_age) begin
          w_best_age = r_age[v];
          w_sel      = ID_W'(v);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fcw_req <= '0;
      r_sel     <= '0;
      r_stolen  <= 1'b0;
    end else begin
      if (w_accept) r_fcw_req <= bus.req_fcw;
      if (r_state == S_SELECT) begin
        r_sel    <= w_sel;
        r_stolen <= w_stolen;
      end
    end
  end

  // Pending bridges the cycle before adsr_idle drops after a start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      for (int v = 0; v < N_VOICE; v++) begin
        r_age[v]       <= '1;
        r_voice_fcw[v] <= '0;
      end
    end else begin
      for (int v = 0; v < N_VOICE; v++) begin
        if (w_start[v]) begin
          r_pending[v]   <= 1'b1;
          r_age[v]       <= '0;
          r_voice_fcw[v] <= r_fcw_req;
        end else begin
          if (r_pending[v] && !i_voice_idle[v]) r_pending[v] <= 1'b0;
          if (r_age[v] != '1) r_age[v] <= r_age[v] + AGE_W'(1);
        end
      end
    end
  end

  for (genvar v = 0; v < N_VOICE; v++) begin : g_fcw_flat
    assign o_voice_fcw[v*FCW_W +: FCW_W] = r_voice_fcw[v];
  end

  assign w_busy = ~i_voice_idle | r_pending;

  always_comb begin
    w_cnt = '0;
    for (int v = 0; v < N_VOICE; v++) begin
      w_cnt = w_cnt + CNT_W'(w_busy[v]);
    end
  end

  assign o_active_cnt = w_cnt;

endmodule
`default_nettype wire

// File: doc/adsr_voice_alloc.md
Name: adsr_voice_alloc

Overview:
Voice allocator/scheduler that shares N_VOICE envelope-generator voices (ADSR + tone DDS per voice) among a stream of note-on requests. It accepts a request carrying a DDS frequency control word and selects a voice: a free voice if one exists, otherwise the oldest busy voice is stolen. It then loads that voice's FCW and pulses its one-cycle start. It sits between the MMIO note register/FIFO and the per-voice ADSR/DDS instances in the synth subsystem.

Parameters:
N_VOICE, 4, number of voices managed (2..16)
FCW_W, 32, width of per-voice DDS frequency control word
AGE_W, 16, width of per-voice age counter (saturating)

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
req_valid  in  1  note-on request present
req_ready  out  1  allocator can accept request this cycle
req_fcw  in  FCW_W  frequency control word of requested note
voice_idle  in  N_VOICE  per-voice ADSR idle flag (adsr_idle of each voice)
voice_start  out  N_VOICE  one-cycle start pulse per voice, to ADSR start
voice_fcw  out  N_VOICE*FCW_W  flattened per-voice FCW; voice v at [v*FCW_W +: FCW_W]
grant_valid  out  1  one-cycle pulse: a voice was started
grant_id  out  $clog2(N_VOICE)  index of started voice, valid with grant_valid
grant_stolen  out  1  started voice was busy (stolen), valid with grant_valid
active_cnt  out  $clog2(N_VOICE)+1  number of voices busy or pending

Behaviour:
- Reset: state=IDLE; req_ready=1; voice_start, grant_valid, grant_stolen, grant_id=0; all voice_fcw=0; pending bits=0; ages=all-ones (max, so all voices count as old). active_cnt follows its combinational definition.
- FSM states: IDLE, SELECT, ISSUE.
- IDLE: req_ready=1. On req_valid & req_ready, latch req_fcw into fcw_reg and go to SELECT. Otherwise stay.
- SELECT (req_ready=0): compute free[v] = voice_idle[v] & ~pending[v].
  - If any free: sel = lowest-index free voice, stolen=0.
  - Else: sel = voice with the largest age. Ties go to the lowest index. stolen=1.
  - Register sel/stolen, go to ISSUE.
- ISSUE (req_ready=0): voice_start[sel]=1 for exactly this cycle. voice_fcw[sel]<=fcw_reg, updated at the end of this cycle; other voices' FCW are unchanged. Set pending[sel], age[sel]<=0, grant_valid=1, grant_id=sel, grant_stolen=stolen. Go to IDLE.
- Timing: accept at cycle T, start pulse at T+2, next accept possible at T+3. Maximum throughput is 1 request per 3 cycles. No combinational path from req_valid to req_ready.
- Outputs voice_start, grant_* are registered or decoded from state only; they are glitch-free single-cycle pulses.
- Pending bit: covers the ADSR latency, where adsr_idle falls one cycle after start.
  - Set in ISSUE.
  - Cleared on the first cycle after ISSUE in which voice_idle[v]=0 is observed.
  - A stolen (already busy) voice clears on the following cycle.
- Age: each cycle, age[v] increments (saturating at all-ones) for every v not being started. The voice being started loads 0. Counting runs in all states.
- active_cnt = popcount(~voice_idle | pending), combinational.
- Boundaries:
  - All voices busy: steal always succeeds; the allocator never stalls on voice availability.
  - req_valid dropped while in SELECT/ISSUE: no effect; the request is already latched.
  - A voice finishing (voice_idle rising) during SELECT is eligible only if sampled in SELECT.
  - Reset mid-operation: immediate return to reset values. No start pulse is issued for the in-flight request, and voice_fcw clears to 0.
  - Age saturation: a saturated age never wraps to 0.

Test Plan:
- Reset, voice_idle=4'b1111, single req fcw=0x0000_1234 accepted at T -> voice_start=4'b0001 at T+2 only; grant_id=0, grant_stolen=0; voice_fcw[0]=0x1234 from T+3; req_ready high again at T+3.
- 4 back-to-back requests (fcw 1,2,3,4), model each ADSR dropping idle 1 cycle after start -> voices 0,1,2,3 started in order; active_cnt=4; no steals.
- All busy after the above, 5th req fcw=5 -> voice 0 (oldest) stolen, grant_stolen=1, voice_fcw[0]=5; 6th req steals voice 1.
- Voices 0,1,3 busy, voice 2 returns idle (voice_idle=4'b0100) -> next req gets grant_id=2, grant_stolen=0.
- Request accepted immediately after a start, before voice_idle falls (pending still set) -> that voice is skipped; next lowest free voice chosen.
- Assert reset during SELECT -> no voice_start pulse, all voice_fcw=0, req_ready=1 after reset release; next req goes to voice 0.
